// File: rtl/game_pkg.sv
// Shared types and default constants for the pacman game core.
// Combinational only; nothing here adds latency.
// No flow control; pure definitions.
package game_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    DYING = 2'd1,
    OVER  = 2'd2
  } lives_state_t;

  localparam int MAX_LIVES_DEF        = 3;
  localparam int START_LIVES_DEF      = 3;
  localparam int DEATH_HOLD_DEF       = 60;
  localparam int SCORE_W_DEF          = 16;
  localparam int EXTRA_LIFE_SCORE_DEF = 10000;

  // Saturating increment used for the lives count, on plain integers.
  function automatic int sat_inc(input int cur, input int ceiling);
    return (cur >= ceiling) ? ceiling : cur + 1;
  endfunction

endpackage

// File: rtl/lives_ctrl_death_timer.sv
// Down-counter that times the DYING hold; Zero flags an expired (or idle) count.
// Load takes effect on the next edge; one decrement per cycle while Dec is high.
// No backpressure; Clear wins over Load, which wins over Dec.
module death_timer #(
  parameter int DEATH_HOLD = game_pkg::DEATH_HOLD_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Load,
  input  logic Dec,
  output logic Zero
);

  localparam int TW = $clog2(DEATH_HOLD + 1);

  logic [TW-1:0] cnt;

  // Load the hold length minus one so the DYING phase lasts exactly DEATH_HOLD cycles.
  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      cnt <= '0;
    end else if (Load) begin
      cnt <= TW'(DEATH_HOLD - 1);
    end else if (Dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign Zero = (cnt == '0);

endmodule

// File: rtl/lives_ctrl.sv
// Player-lives controller: death -> hold -> respawn sequencing, game-over, optional bonus life.
// All outputs registered; each reacts one cycle after the input that triggers it.
// No backpressure; Start overrides Death and the bonus award. Bonus enabled by LIVES_EXTRA_LIFE_EN.
module lives_ctrl
  import game_pkg::*;
#(
  parameter int MAX_LIVES        = MAX_LIVES_DEF,
  parameter int START_LIVES      = START_LIVES_DEF,
  parameter int DEATH_HOLD       = DEATH_HOLD_DEF,
  parameter int SCORE_W          = SCORE_W_DEF,
  parameter int EXTRA_LIFE_SCORE = EXTRA_LIFE_SCORE_DEF
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Start,
  input  logic                           Death,
  input  logic [SCORE_W-1:0]             Score,
  output logic [$clog2(MAX_LIVES+1)-1:0] Lives,
  output logic                           Dying,
  output logic                           Respawn,
  output logic                           Game_over,
  output logic                           Reset_game,
  output logic                           Extra_life
);

  localparam int LW = $clog2(MAX_LIVES + 1);

  lives_state_t state;
  logic         award;
  logic         tmr_load;
  logic         tmr_dec;
  logic         tmr_zero;
  logic [LW-1:0] lives_inc;

`ifdef LIVES_EXTRA_LIFE_EN
  logic bonus_taken;

  assign award = !bonus_taken && (Score >= SCORE_W'(EXTRA_LIFE_SCORE)) && (state != OVER);

  // One bonus per game: consumed on award, re-armed only by Start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bonus_taken <= 1'b0;
      Extra_life  <= 1'b0;
    end else if (Start) begin
      bonus_taken <= 1'b0;
      Extra_life  <= 1'b0;
    end else begin
      Extra_life <= award;
      if (award) bonus_taken <= 1'b1;
    end
  end
`else
  logic score_unused;

  assign award        = 1'b0;
  assign Extra_life   = 1'b0;
  assign score_unused = (^Score) ^ (EXTRA_LIFE_SCORE != 0);
`endif

  assign lives_inc = LW'(sat_inc(int'(Lives), MAX_LIVES));

  // Timer control: arm on a survivable death in PLAY, count down while DYING.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    if (!Start) begin
      tmr_load = (state == PLAY) && Death && (award || (Lives > LW'(1)));
      tmr_dec  = (state == DYING) && !tmr_zero;
    end
  end

  death_timer #(
    .DEATH_HOLD (DEATH_HOLD)
  ) u_death_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (Start),
    .Load  (tmr_load),
    .Dec   (tmr_dec),
    .Zero  (tmr_zero)
  );

  // Lives register and game FSM; a death with a same-cycle award nets out to no change.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= PLAY;
      Lives      <= LW'(START_LIVES);
      Dying      <= 1'b0;
      Respawn    <= 1'b0;
      Game_over  <= 1'b0;
      Reset_game <= 1'b0;
    end else begin
      Respawn    <= 1'b0;
      Reset_game <= 1'b0;
      if (Start) begin
        state     <= PLAY;
        Lives     <= LW'(START_LIVES);
        Dying     <= 1'b0;
        Game_over <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (Death) begin
              if (award || (Lives > LW'(1))) begin
                state <= DYING;
                Dying <= 1'b1;
                Lives <= award ? Lives : Lives - 1'b1;
              end else begin
                state      <= OVER;
                Lives      <= '0;
                Game_over  <= 1'b1;
                Reset_game <= 1'b1;
              end
            end else if (award) begin
              Lives <= lives_inc;
            end
          end
          DYING: begin
            if (award) Lives <= lives_inc;
            if (tmr_zero) begin
              state   <= PLAY;
              Dying   <= 1'b0;
              Respawn <= 1'b1;
            end
          end
          OVER: begin
            Game_over <= 1'b1;
          end
          default: begin
            state <= PLAY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lives_ctrl.sv
module tb_lives_ctrl;

  localparam int MAX_L  = 3;
  localparam int START_L = 3;
  localparam int HOLD   = 4;
  localparam int THR    = 100;

`ifdef LIVES_EXTRA_LIFE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  localparam int PH_PLAY  = 0;
  localparam int PH_DYING = 1;
  localparam int PH_OVER  = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Death = 1'b0;
  logic [15:0] Score = '0;
  logic [1:0]  Lives;
  logic        Dying, Respawn, Game_over, Reset_game, Extra_life;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed in game terms.
  int m_lives;
  int m_phase;
  int m_left;      // DYING cycles still to show, including the current one
  bit m_bonus;
  bit e_resp, e_rg, e_xl;

  logic [6:0] dut_vec;
  assign dut_vec = {Lives, Dying, Respawn, Game_over, Reset_game, Extra_life};

  lives_ctrl #(
    .MAX_LIVES        (MAX_L),
    .START_LIVES      (START_L),
    .DEATH_HOLD       (HOLD),
    .SCORE_W          (16),
    .EXTRA_LIFE_SCORE (THR)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Death      (Death),
    .Score      (Score),
    .Lives      (Lives),
    .Dying      (Dying),
    .Respawn    (Respawn),
    .Game_over  (Game_over),
    .Reset_game (Reset_game),
    .Extra_life (Extra_life)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] exp_vec();
    logic [1:0] l;
    l = m_lives[1:0];
    return {l, (m_phase == PH_DYING), e_resp, (m_phase == PH_OVER), e_rg, e_xl};
  endfunction

  task automatic model_update(input bit rst, input bit st, input bit dth, input int sc);
    bit aw;
    e_resp = 1'b0;
    e_rg   = 1'b0;
    e_xl   = 1'b0;
    if (rst || st) begin
      m_lives = START_L;
      m_phase = PH_PLAY;
      m_left  = 0;
      m_bonus = 1'b0;
      return;
    end
    aw = EN && !m_bonus && (sc >= THR) && (m_phase != PH_OVER);
    if (m_phase == PH_PLAY) begin
      if (dth) begin
        if (m_lives > 1 || aw) begin
          if (m_lives >= 1) m_lives = m_lives - 1;
          m_phase = PH_DYING;
          m_left  = HOLD;
        end else begin
          m_lives = 0;
          m_phase = PH_OVER;
          e_rg    = 1'b1;
        end
      end
    end else if (m_phase == PH_DYING) begin
      if (m_left <= 1) begin
        m_phase = PH_PLAY;
        e_resp  = 1'b1;
      end else begin
        m_left = m_left - 1;
      end
    end
    if (aw) begin
      m_bonus = 1'b1;
      e_xl    = 1'b1;
      m_lives = (m_lives + 1 > MAX_L) ? MAX_L : m_lives + 1;
    end
  endtask

  task automatic tick(input bit rst, input bit st, input bit dth, input int sc);
    Reset = rst;
    Start = st;
    Death = dth;
    Score = sc[15:0];
    @(posedge Clk);
    model_update(rst, st, dth, sc);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_held: dut=%b expected=%b", dut_vec, exp_vec());
    end
    tick(0, 0, 0, 0);
    checks++;
    if (dut_vec !== 7'b11_00000) begin
      errors++;
      $display("FAIL reset_release: dut=%b expected=%b", dut_vec, 7'b11_00000);
    end
  endtask

  task automatic test_death_hold();
    int dying_cnt;
    int resp_cnt;
    bit d;
    tick(0, 0, 1, 0);
    checks++;
    if (Lives !== 2'd2 || Dying !== 1'b1) begin
      errors++;
      $display("FAIL death_entry: lives=%0d dying=%b expected lives=2 dying=1", Lives, Dying);
    end
    dying_cnt = 1;
    resp_cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      d = (m_phase == PH_DYING);
      tick(0, 0, d, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL death_hold step %0d: dut=%b expected=%b", i, dut_vec, exp_vec());
      end
      if (Dying === 1'b1) dying_cnt++;
      if (Respawn === 1'b1) resp_cnt++;
    end
    checks++;
    if (dying_cnt != HOLD || resp_cnt != 1 || Lives !== 2'd2) begin
      errors++;
      $display("FAIL death_hold_len: dying=%0d respawn=%0d lives=%0d expected 4/1/2", dying_cnt, resp_cnt, Lives);
    end
  endtask

  task automatic test_game_over();
    int seen [3];
    bit rg_at_over, go_at_over;
    tick(0, 1, 0, 0);
    for (int d = 0; d < 3; d++) begin
      tick(0, 0, 1, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL game_over death %0d: dut=%b expected=%b", d, dut_vec, exp_vec());
      end
      seen[d] = int'(Lives);
      rg_at_over = Reset_game;
      go_at_over = Game_over;
      if (d < 2) begin
        for (int k = 0; k < 8; k++) begin
          tick(0, 0, 0, 0);
          checks++;
          if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL game_over hold %0d/%0d: dut=%b expected=%b", d, k, dut_vec, exp_vec());
          end
        end
      end
    end
    checks++;
    if (seen[0] != 2 || seen[1] != 1 || seen[2] != 0 || !rg_at_over || !go_at_over) begin
      errors++;
      $display("FAIL game_over_seq: lives %0d,%0d,%0d rg=%b go=%b expected 2,1,0 1 1",
               seen[0], seen[1], seen[2], rg_at_over, go_at_over);
    end
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1, 0);
      checks++;
      if (dut_vec !== 7'b00_00100 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL over_ignores_death %0d: dut=%b expected=%b", k, dut_vec, 7'b00_00100);
      end
    end
  endtask

  task automatic test_start();
    tick(0, 1, 0, 0);
    checks++;
    if (Lives !== 2'd3 || Game_over !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL start_from_over: dut=%b expected=%b", dut_vec, exp_vec());
    end
    tick(0, 1, 1, 0);
    checks++;
    if (Lives !== 2'd3 || Dying !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL start_beats_death: dut=%b expected=%b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_bonus();
    int pulses;
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    for (int k = 0; k < 8; k++) tick(0, 0, 0, 0);
    tick(0, 0, 0, 99);
    checks++;
    if (dut_vec !== exp_vec() || Extra_life !== 1'b0) begin
      errors++;
      $display("FAIL bonus_below: dut=%b expected=%b", dut_vec, exp_vec());
    end
    tick(0, 0, 0, 100);
    checks++;
    if (dut_vec !== exp_vec() || Extra_life !== EN || Lives !== (EN ? 2'd3 : 2'd2)) begin
      errors++;
      $display("FAIL bonus_award: dut=%b expected=%b", dut_vec, exp_vec());
    end
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 150);
      if (Extra_life === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL bonus_once: extra_life pulses=%0d expected 0", pulses);
    end
    tick(0, 1, 0, 150);
    tick(0, 0, 0, 150);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL bonus_rearm: dut=%b expected=%b", dut_vec, exp_vec());
    end
    tick(0, 1, 0, 0);
    for (int d = 0; d < 2; d++) begin
      tick(0, 0, 1, 0);
      for (int k = 0; k < 8; k++) tick(0, 0, 0, 0);
    end
    tick(0, 0, 1, 100);
    checks++;
    if (dut_vec !== exp_vec() || Lives !== (EN ? 2'd1 : 2'd0) || Dying !== EN || Game_over !== !EN) begin
      errors++;
      $display("FAIL bonus_saves_last: dut=%b expected=%b", dut_vec, exp_vec());
    end
    tick(0, 0, 0, 100);
    tick(1, 0, 0, 100);
    checks++;
    if (dut_vec !== exp_vec() || Lives !== 2'd3 || Dying !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dying: dut=%b expected=%b", dut_vec, exp_vec());
    end
    tick(0, 0, 0, 100);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL after_reset_award: dut=%b expected=%b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    bit r, s, d;
    int sc;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      s  = ($urandom_range(0, 29) == 0);
      d  = ($urandom_range(0, 5) == 0);
      sc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 300)) : int'($urandom_range(0, 99));
      tick(r, s, d, sc);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: dut=%b expected=%b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    m_lives = START_L;
    m_phase = PH_PLAY;
    m_left  = 0;
    m_bonus = 1'b0;
    e_resp  = 1'b0;
    e_rg    = 1'b0;
    e_xl    = 1'b0;
    @(negedge Clk);
    test_reset();
    test_death_hold();
    test_game_over();
    test_start();
    test_bonus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
